row_deser_hq: RTL



---
 rtl/soml_pkg.sv | 19 +
 rtl/row_deser_hq_if.sv | 29 ++
 rtl/row_shift_reg.sv | 30 +++
 rtl/row_deser_hq.sv | 93 +++++++++
 4 files changed

// File: rtl/soml_pkg.sv
// soml_pkg: shared defaults, FSM encoding and size helpers for the SOML front end
package soml_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  function automatic int row_w(input int sample_w, input int words_per_row);
    return sample_w * words_per_row;
  endfunction

  function automatic int frame_len(input int num_rows, input int words_per_row);
    return num_rows * words_per_row;
  endfunction

endpackage

// File: rtl/row_deser_hq_if.sv
// row_deser_hq_if: sample stream in, collected H rows and status out
interface row_deser_hq_if
  import soml_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int WORDS_PER_ROW = 2,
  parameter int NUM_ROWS      = 4
);
  localparam int ROW_W = row_w(SAMPLE_W, WORDS_PER_ROW);
  logic                      start;
  logic                      in_valid;
  logic [SAMPLE_W-1:0]       sdr;
  logic [SAMPLE_W-1:0]       sdi;
  logic [NUM_ROWS*ROW_W-1:0] out_rowHr;
  logic [NUM_ROWS*ROW_W-1:0] out_rowHi;
  logic                      frame_done;
  logic                      busy;
  logic                      err_abort;

  modport master (
    output start, in_valid, sdr, sdi,
    input  out_rowHr, out_rowHi, frame_done, busy, err_abort
  );

  modport slave (
    input  start, in_valid, sdr, sdi,
    output out_rowHr, out_rowHi, frame_done, busy, err_abort
  );
endinterface

// File: rtl/row_shift_reg.sv
// row_shift_reg: one row of H, shifting samples in from the LSB end
module row_shift_reg
  import soml_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int WORDS_PER_ROW = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              shift_en,
  input  logic [SAMPLE_W-1:0]               din,
  output logic [SAMPLE_W*WORDS_PER_ROW-1:0] q
);
  localparam int ROW_W = row_w(SAMPLE_W, WORDS_PER_ROW);

  if (WORDS_PER_ROW == 1) begin : g_load
    // a single-word row simply takes the sample; clr wipes it unless a sample lands
    always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else q <= shift_en ? din : (clr ? '0 : q);
  end else begin : g_shift
    // clr drops stale words so a restart sample becomes word 0 of a clean row
    always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (shift_en) q <= {(clr ? {(ROW_W-SAMPLE_W){1'b0}} : q[ROW_W-SAMPLE_W-1:0]), din};
      else if (clr) q <= '0;
  end

endmodule

// File: rtl/row_deser_hq.sv
// row_deser_hq: deserialises sdr/sdi sample pairs into NUM_ROWS rows of H
module row_deser_hq
  import soml_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int WORDS_PER_ROW = 2,
  parameter int NUM_ROWS      = 4
) (
  input logic          clk,
  input logic          rst,
  row_deser_hq_if.slave bus
);
  localparam int ROW_W = row_w(SAMPLE_W, WORDS_PER_ROW);
  localparam int WC_W  = WORDS_PER_ROW > 1 ? $clog2(WORDS_PER_ROW) : 1;
  localparam int RC_W  = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;

  state_t                    state, state_n;
  logic [WC_W-1:0]           word_cnt, wc_base, wc_n;
  logic [RC_W-1:0]           row_cnt, rc_base, rc_n;
  logic                      accept, wc_wrap, last, complete, abort;
  logic [ROW_W-1:0]          q_r [NUM_ROWS];
  logic [ROW_W-1:0]          q_i [NUM_ROWS];
  logic [NUM_ROWS*ROW_W-1:0] nxt_r, nxt_i;

  // next-state and counter logic; start rebases the counters to zero before the sample is counted
  always_comb begin
    accept   = bus.in_valid && (state == ST_COLLECT || bus.start);
    wc_base  = bus.start ? '0 : word_cnt;
    rc_base  = bus.start ? '0 : row_cnt;
    wc_wrap  = wc_base == WC_W'(WORDS_PER_ROW-1);
    last     = wc_wrap && rc_base == RC_W'(NUM_ROWS-1);
    complete = accept && last && !bus.start;
    abort    = bus.start && state == ST_COLLECT && (word_cnt != '0 || row_cnt != '0);
    wc_n     = accept ? (wc_wrap ? '0 : wc_base + WC_W'(1)) : wc_base;
    rc_n     = accept && wc_wrap ? (rc_base == RC_W'(NUM_ROWS-1) ? '0 : rc_base + RC_W'(1)) : rc_base;
    state_n  = bus.start ? ST_COLLECT : (complete ? ST_IDLE : state);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_n;

  // word/row position within the frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      word_cnt <= wc_n;
      row_cnt  <= rc_n;
    end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic en;
    assign en = accept && rc_base == RC_W'(r);
    row_shift_reg #(.SAMPLE_W(SAMPLE_W), .WORDS_PER_ROW(WORDS_PER_ROW)) u_re (
      .clk(clk), .rst(rst), .clr(bus.start), .shift_en(en), .din(bus.sdr), .q(q_r[r])
    );
    row_shift_reg #(.SAMPLE_W(SAMPLE_W), .WORDS_PER_ROW(WORDS_PER_ROW)) u_im (
      .clk(clk), .rst(rst), .clr(bus.start), .shift_en(en), .din(bus.sdi), .q(q_i[r])
    );
    if (r != NUM_ROWS-1) begin : g_mid
      assign nxt_r[r*ROW_W +: ROW_W] = q_r[r];
      assign nxt_i[r*ROW_W +: ROW_W] = q_i[r];
    end else if (WORDS_PER_ROW == 1) begin : g_last1
      assign nxt_r[r*ROW_W +: ROW_W] = bus.sdr;
      assign nxt_i[r*ROW_W +: ROW_W] = bus.sdi;
    end else begin : g_lastn
      assign nxt_r[r*ROW_W +: ROW_W] = {q_r[r][ROW_W-SAMPLE_W-1:0], bus.sdr};
      assign nxt_i[r*ROW_W +: ROW_W] = {q_i[r][ROW_W-SAMPLE_W-1:0], bus.sdi};
    end
  end

  // presented rows update only on completion, with the arriving sample folded into the last row
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.out_rowHr  <= '0;
      bus.out_rowHi  <= '0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err_abort  <= 1'b0;
    end else begin
      bus.frame_done <= complete;
      bus.err_abort  <= abort;
      bus.busy       <= state_n == ST_COLLECT;
      if (complete) begin
        bus.out_rowHr <= nxt_r;
        bus.out_rowHi <= nxt_i;
      end
    end

endmodule
